// File: rtl/idecode_pkg.sv
// Shared definitions for the instruction-decode stage: instruction field
// positions, opcode width and the immediate-extension helper.
package idecode_pkg;

  localparam int OPW       = 4;
  localparam int OP_MSB    = 31;
  localparam int OP_LSB    = 28;
  localparam int RD_MSB    = 27;
  localparam int RD_LSB    = 22;
  localparam int RS_MSB    = 21;
  localparam int RS_LSB    = 16;
  localparam int RT_MSB    = 15;
  localparam int RT_LSB    = 10;
  localparam int IMM22_MSB = 21;
  localparam int IMM16_MSB = 15;
  localparam int LIMM_BIT  = 0;

  // Field is inst[21:0]; bit LIMM_BIT selects the 22-bit form over the 16-bit one.
  function automatic logic [63:0] ext_imm(input logic [IMM22_MSB:0] field,
                                          input logic sext);
    logic [63:0] r;
    if (field[LIMM_BIT])
      r = {{(63 - IMM22_MSB){sext & field[IMM22_MSB]}}, field[IMM22_MSB:0]};
    else
      r = {{(63 - IMM16_MSB){sext & field[IMM16_MSB]}}, field[IMM16_MSB:0]};
    return r;
  endfunction

endpackage

// File: rtl/idecode_pipe_regfile.sv
// Register file: NREG x XLEN, two combinational read ports, one write port.
// Contents are deliberately not reset.
module regfile_2r1w #(
  parameter int XLEN = 32,
  parameter int NREG = 64,
  parameter int AW   = $clog2(NREG)
) (
  input  logic            clk,
  input  logic [AW-1:0]   ra_a,
  output logic [XLEN-1:0] rdata_a,
  input  logic [AW-1:0]   ra_b,
  output logic [XLEN-1:0] rdata_b,
  input  logic            we,
  input  logic [AW-1:0]   wa,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] mem [NREG];

  always_ff @(posedge clk) begin
    if (we)
      mem[wa] <= wdata;
  end

  assign rdata_a = mem[ra_a];
  assign rdata_b = mem[ra_b];

endmodule

// File: rtl/idecode_pipe.sv
// Instruction-decode stage with handshakes, output register, RAW scoreboard and flush.
// Define IDECODE_WB_BYPASS_EN to forward same-cycle write-back data and drop the post-write-back bubble.
module idecode_pipe
  import idecode_pkg::*;
#(
  parameter int          XLEN       = 32,
  parameter int          NREG       = 64,
  parameter int          AW         = $clog2(NREG),
  parameter bit          IMM_SEXT   = 1'b1,
  parameter logic [15:0] WB_OP_MASK = 16'hFFFE
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] pci,
  input  logic [31:0]     inst,
  input  logic            svpc,
  input  logic            flush,
  input  logic            rw,
  input  logic [AW-1:0]   rdi,
  input  logic [XLEN-1:0] wd,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] pco,
  output logic [XLEN-1:0] lhs,
  output logic [XLEN-1:0] rhs,
  output logic [XLEN-1:0] imm,
  output logic [AW-1:0]   rdo,
  output logic [OPW-1:0]  opo,
  output logic            wbo
);

  logic [5:0]      rd_field, rs_field, rt_field;
  logic [AW-1:0]   rd_addr, rs_addr, rt_addr;
  logic [OPW-1:0]  op;
  logic [XLEN-1:0] rf_rs, rf_rt, rs_val, rt_val, lhs_val, imm_ext;
  logic [NREG-1:0] sb_reg, sb_next, sb_eff, wb_clr, wb_set;
  logic            pend_rs, pend_rt, hazard, accept, handoff;

  logic            out_valid_reg, wbo_reg;
  logic [XLEN-1:0] pco_reg, lhs_reg, rhs_reg, imm_reg;
  logic [AW-1:0]   rdo_reg;
  logic [OPW-1:0]  opo_reg;

  assign rd_field = inst[RD_MSB:RD_LSB];
  assign rs_field = inst[RS_MSB:RS_LSB];
  assign rt_field = inst[RT_MSB:RT_LSB];
  assign rd_addr  = rd_field[AW-1:0];
  assign rs_addr  = rs_field[AW-1:0];
  assign rt_addr  = rt_field[AW-1:0];
  assign op       = inst[OP_MSB:OP_LSB];

  regfile_2r1w #(.XLEN(XLEN), .NREG(NREG), .AW(AW)) u_rf (
    .clk     (clk),
    .ra_a    (rs_addr),
    .rdata_a (rf_rs),
    .ra_b    (rt_addr),
    .rdata_b (rf_rt),
    .we      (rw),
    .wa      (rdi),
    .wdata   (wd)
  );

  assign wb_clr = rw ? (NREG'(1) << rdi) : '0;

`ifdef IDECODE_WB_BYPASS_EN
  assign rs_val = (rw && (rdi == rs_addr)) ? wd : rf_rs;
  assign rt_val = (rw && (rdi == rt_addr)) ? wd : rf_rt;
  // A bit being cleared this cycle no longer blocks its consumer.
  assign sb_eff = sb_reg & ~wb_clr;
`else
  assign rs_val = rf_rs;
  assign rt_val = rf_rt;
  assign sb_eff = sb_reg;
`endif

  // A producer still sitting in the output register has not reached the scoreboard yet.
  assign pend_rs = sb_eff[rs_addr] || (out_valid_reg && wbo_reg && (rdo_reg == rs_addr));
  assign pend_rt = sb_eff[rt_addr] || (out_valid_reg && wbo_reg && (rdo_reg == rt_addr));
  assign hazard  = (!svpc && pend_rs) || pend_rt;

  assign in_ready = (!out_valid_reg || out_ready) && !hazard && !flush;
  assign accept   = in_valid && in_ready;
  assign handoff  = out_valid_reg && out_ready && !flush;

  assign lhs_val = svpc ? pci : rs_val;
  assign imm_ext = XLEN'(ext_imm(inst[IMM22_MSB:0], IMM_SEXT));

  // Handoff set is applied after the write-back clear so it wins on a collision.
  assign wb_set  = (handoff && wbo_reg) ? (NREG'(1) << rdo_reg) : '0;
  assign sb_next = (sb_reg & ~wb_clr) | wb_set;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      sb_reg <= '0;
    else
      sb_reg <= sb_next;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_reg <= 1'b0;
      pco_reg       <= '0;
      lhs_reg       <= '0;
      rhs_reg       <= '0;
      imm_reg       <= '0;
      rdo_reg       <= '0;
      opo_reg       <= '0;
      wbo_reg       <= 1'b0;
    end else if (flush) begin
      out_valid_reg <= 1'b0;
    end else if (accept) begin
      out_valid_reg <= 1'b1;
      pco_reg       <= pci;
      lhs_reg       <= lhs_val;
      rhs_reg       <= rt_val;
      imm_reg       <= imm_ext;
      rdo_reg       <= rd_addr;
      opo_reg       <= op;
      wbo_reg       <= WB_OP_MASK[op];
    end else if (handoff) begin
      out_valid_reg <= 1'b0;
    end
  end

  assign out_valid = out_valid_reg;
  assign pco       = pco_reg;
  assign lhs       = lhs_reg;
  assign rhs       = rhs_reg;
  assign imm       = imm_reg;
  assign rdo       = rdo_reg;
  assign opo       = opo_reg;
  assign wbo       = wbo_reg;

endmodule

// File: tb/tb_idecode_pipe.sv
// Self-checking bench for idecode_pipe: behavioural model + per-cycle compare, plus directed literal checks.
module tb_idecode_pipe;

  localparam int XLEN = 32;
  localparam int NREG = 64;
  localparam int AW   = 6;
`ifdef IDECODE_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  logic            in_valid, svpc, flush, rw, out_ready;
  logic [XLEN-1:0] pci, wd;
  logic [31:0]     inst;
  logic [AW-1:0]   rdi;

  logic            in_ready, out_valid, wbo;
  logic [XLEN-1:0] pco, lhs, rhs, imm;
  logic [AW-1:0]   rdo;
  logic [3:0]      opo;

  logic            in_ready0, out_valid0, wbo0;
  logic [XLEN-1:0] pco0, lhs0, rhs0, imm0;
  logic [AW-1:0]   rdo0;
  logic [3:0]      opo0;

  idecode_pipe #(.XLEN(XLEN), .NREG(NREG), .IMM_SEXT(1'b1)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .pci(pci), .inst(inst), .svpc(svpc), .flush(flush),
    .rw(rw), .rdi(rdi), .wd(wd),
    .out_valid(out_valid), .out_ready(out_ready),
    .pco(pco), .lhs(lhs), .rhs(rhs), .imm(imm), .rdo(rdo), .opo(opo), .wbo(wbo)
  );

  // Zero-extending twin, driven identically; only its immediate is examined.
  idecode_pipe #(.XLEN(XLEN), .NREG(NREG), .IMM_SEXT(1'b0)) dut0 (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready0),
    .pci(pci), .inst(inst), .svpc(svpc), .flush(flush),
    .rw(rw), .rdi(rdi), .wd(wd),
    .out_valid(out_valid0), .out_ready(out_ready),
    .pco(pco0), .lhs(lhs0), .rhs(rhs0), .imm(imm0), .rdo(rdo0), .opo(opo0), .wbo(wbo0)
  );

  int checks = 0;
  int failures = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  logic [31:0] m_rf [64];
  bit          m_sb [64];
  bit          m_v, m_wb;
  logic [31:0] m_pc, m_lhs, m_rhs, m_imm, m_imm0;
  int          m_rd, m_op;

  function automatic logic [31:0] m_immf(input logic [31:0] i, input bit sext);
    longint w, v;
    w = i[0] ? 22 : 16;
    v = longint'(i) & ((64'sd1 <<< w) - 1);
    if (sext && v >= (64'sd1 <<< (w - 1)))
      v = v - (64'sd1 <<< w);
    return v[31:0];
  endfunction

  function automatic bit m_pend(input int r);
    bit cleared_now;
    cleared_now = BYP && rw && (int'(rdi) == r);
    return (m_sb[r] && !cleared_now) || (m_v && m_wb && m_rd == r);
  endfunction

  function automatic bit m_ready();
    int rs, rt;
    rs = int'(inst[21:16]);
    rt = int'(inst[15:10]);
    return (!m_v || out_ready) && !((!svpc && m_pend(rs)) || m_pend(rt)) && !flush;
  endfunction

  function automatic logic [31:0] m_read(input int r);
    return (BYP && rw && int'(rdi) == r) ? wd : m_rf[r];
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_v <= 1'b0; m_wb <= 1'b0; m_pc <= '0; m_lhs <= '0; m_rhs <= '0;
      m_imm <= '0; m_imm0 <= '0; m_rd <= 0; m_op <= 0;
      for (int i = 0; i < 64; i++) m_sb[i] <= 1'b0;
    end else begin
      for (int i = 0; i < 64; i++)
        m_sb[i] <= (m_v && out_ready && !flush && m_wb && m_rd == i) ? 1'b1 :
                   (rw && int'(rdi) == i) ? 1'b0 : m_sb[i];
      if (rw) m_rf[rdi] <= wd;
      if (flush)
        m_v <= 1'b0;
      else if (in_valid && m_ready()) begin
        m_v    <= 1'b1;
        m_pc   <= pci;
        m_lhs  <= svpc ? pci : m_read(int'(inst[21:16]));
        m_rhs  <= m_read(int'(inst[15:10]));
        m_imm  <= m_immf(inst, 1'b1);
        m_imm0 <= m_immf(inst, 1'b0);
        m_rd   <= int'(inst[27:22]);
        m_op   <= int'(inst[31:28]);
        m_wb   <= (inst[31:28] != 4'd0);
      end else if (m_v && out_ready)
        m_v <= 1'b0;
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      chk("cyc_in_ready", in_ready, m_ready());
      chk("cyc_out_valid", out_valid, m_v);
      if (m_v) begin
        chk("cyc_pco", pco, m_pc);
        chk("cyc_lhs", lhs, m_lhs);
        chk("cyc_rhs", rhs, m_rhs);
        chk("cyc_imm", imm, m_imm);
        chk("cyc_imm_zext", imm0, m_imm0);
        chk("cyc_rdo", rdo, m_rd);
        chk("cyc_opo", opo, m_op);
        chk("cyc_wbo", wbo, m_wb);
      end
    end
  end

  // ---------------- stimulus ----------------
  function automatic logic [31:0] mk(input int op, input int rd, input int rs,
                                     input int rt, input int lo);
    return {op[3:0], rd[5:0], rs[5:0], rt[5:0], lo[9:0]};
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input int r, input logic [31:0] d);
    rw = 1'b1; rdi = r[5:0]; wd = d;
    tick();
    rw = 1'b0;
  endtask

  task automatic send(input logic [31:0] i, input bit sv, input logic [31:0] pc);
    bit done = 1'b0;
    inst = i; svpc = sv; pci = pc; in_valid = 1'b1;
    for (int k = 0; k < 10 && !done; k++) begin
      #1;
      done = in_ready;
      tick();
    end
    in_valid = 1'b0; svpc = 1'b0;
    if (!done) begin
      checks++; failures++;
      $display("FAIL send_timeout: inst 0x%0h not accepted, got in_ready=0, expected 1", i);
    end
  endtask

  // Consumer already presented and stalled; release it with a write-back and time the accept.
  task automatic wb_release(input int r, input logic [31:0] d, input logic [31:0] exp_lhs);
    int  n = 0;
    bit  got = 1'b0;
    rw = 1'b1; rdi = r[5:0]; wd = d;
    for (int k = 0; k < 5 && !got; k++) begin
      #1;
      got = in_ready;
      tick();
      rw = 1'b0;
      if (!got) n++;
    end
    in_valid = 1'b0;
    chk("wb_accept_delay", n, BYP ? 0 : 1);
    chk("wb_out_valid", out_valid, 1);
    chk("wb_lhs", lhs, exp_lhs);
  endtask

  task automatic drain();
    out_ready = 1'b1;
    tick();
  endtask

  initial begin
    in_valid = 0; inst = '0; svpc = 0; pci = '0; flush = 0;
    rw = 0; rdi = '0; wd = '0; out_ready = 1;

    #1 rst_n = 1'b0;
    #2;
    chk("rst_out_valid", out_valid, 0);
    chk("rst_pco", pco, 0);
    chk("rst_lhs", lhs, 0);
    chk("rst_rhs", rhs, 0);
    chk("rst_imm", imm, 0);
    chk("rst_rdo", rdo, 0);
    chk("rst_opo", opo, 0);
    chk("rst_wbo", wbo, 0);
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;

    wr(0, 32'h0); wr(5, 32'h0000_1234); wr(6, 32'hFFFF_0001);
    wr(9, 32'h99); wr(32, 32'h55); wr(63, 32'h6363);

    // basic decode
    send(mk(1, 7, 5, 6, 0), 0, 32'h100);
    chk("t1_valid", out_valid, 1);
    chk("t1_lhs", lhs, 32'h0000_1234);
    chk("t1_rhs", rhs, 32'hFFFF_0001);
    chk("t1_imm", imm, 32'h0000_1800);
    chk("t1_rdo", rdo, 7);
    chk("t1_wbo", wbo, 1);
    chk("t1_pco", pco, 32'h100);
    send(mk(2, 8, 5, 32, 0), 0, 32'h104);
    chk("t1b_imm_sext", imm, 32'hFFFF_8000);
    chk("t1b_imm_zext", imm0, 32'h0000_8000);
    chk("t1b_rhs", rhs, 32'h55);
    wr(7, 32'h77); wr(8, 32'h88);

    // RAW stall released by write-back
    send(mk(3, 3, 0, 0, 0), 0, 32'h110);
    inst = mk(4, 10, 3, 0, 0); pci = 32'h114; in_valid = 1;
    #1 chk("raw_stall_outreg", in_ready, 0);
    tick();
    #1 chk("raw_stall_sb", in_ready, 0);
    wb_release(3, 32'hA5, 32'hA5);
    drain();

    // output hold
    out_ready = 0;
    send(mk(5, 12, 0, 0, 0), 0, 32'h200);
    inst = mk(6, 13, 0, 0, 0); pci = 32'h204; in_valid = 1;
    repeat (3) begin
      #1;
      chk("hold_ready", in_ready, 0);
      chk("hold_valid", out_valid, 1);
      chk("hold_pco", pco, 32'h200);
      tick();
    end
    out_ready = 1;
    #1 chk("release_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("release_valid", out_valid, 1);
    chk("release_pco", pco, 32'h204);
    drain();

    // flush kills producer; its rd never reaches the scoreboard
    out_ready = 0;
    send(mk(7, 9, 0, 0, 0), 0, 32'h300);
    flush = 1;
    #1 chk("flush_ready", in_ready, 0);
    tick();
    flush = 0;
    chk("flush_valid", out_valid, 0);
    out_ready = 1;
    inst = mk(8, 14, 9, 0, 0); pci = 32'h304; in_valid = 1;
    #1 chk("flush_consumer_ready", in_ready, 1);
    tick();
    in_valid = 0;
    chk("flush_consumer_lhs", lhs, 32'h99);
    drain();

    // svpc bypasses the rs check (r12 is scoreboarded)
    inst = mk(9, 15, 12, 0, 0); pci = 32'h400; svpc = 1; in_valid = 1;
    #1 chk("svpc_ready", in_ready, 1);
    tick();
    in_valid = 0; svpc = 0;
    chk("svpc_lhs", lhs, 32'h400);
    drain();

    // long immediate
    send({4'd1, 6'd16, 22'h3F_FFFF}, 0, 32'h500);
    chk("imm22_sext", imm, 32'hFFFF_FFFF);
    chk("imm22_zext", imm0, 32'h003F_FFFF);
    chk("imm22_rhs", rhs, 32'h6363);
    drain();

    // handoff and write-back to the same register in one cycle: set wins
    send(mk(1, 4, 0, 0, 0), 0, 32'h600);
    rw = 1; rdi = 6'd4; wd = 32'h44;
    tick();
    rw = 0;
    inst = mk(2, 17, 4, 0, 0); pci = 32'h604; in_valid = 1;
    repeat (2) begin
      #1 chk("same_edge_stall", in_ready, 0);
      tick();
    end
    wb_release(4, 32'h77, 32'h77);
    drain();

    // mid-operation reset
    out_ready = 0;
    send(mk(3, 20, 0, 0, 0), 0, 32'h700);
    rst_n = 0;
    #1;
    chk("midrst_valid", out_valid, 0);
    chk("midrst_pco", pco, 0);
    chk("midrst_rdo", rdo, 0);
    tick();
    rst_n = 1; out_ready = 1;
    inst = mk(2, 21, 12, 0, 0); pci = 32'h800; in_valid = 1;
    #1 chk("midrst_sb_cleared", in_ready, 1);
    tick();
    in_valid = 0;
    chk("midrst_accept", out_valid, 1);
    drain();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
